i2c_slave_regif: RTL
====================

Name: i2c_slave_regif

Overview:
- I2C target (slave) that responds to the register-pointer transaction format issued by the team's I2C master:
  - write: START, address+W, pointer byte, N data bytes, STOP;
  - read: START, address+W, pointer byte, repeated START, address+R, N data bytes with master ACK/NACK, STOP.
- Bridges the bus to an external 8-bit-addressed register bank through a simple write-strobe / combinational-read interface.
- Sits at chip top behind an open-drain SDA pad; no clock stretching.

Parameters:
- DEV_ADDR, 7'h48, 7-bit bus address this target answers to.

Ports:
- clk  in  1  system clock; must be at least 20x the SCL frequency.
- reset  in  1  asynchronous, active-low reset.
- scl_in  in  1  SCL pad input, asynchronous.
- sda_in  in  1  SDA pad input, asynchronous.
- sda_oe  out  1  1 = pull SDA low, 0 = release; pad tristate is at top level.
- reg_addr  out  8  current register pointer; drives the register bank address for both reads and writes.
- rd_data  in  8  register bank read data; combinational on reg_addr.
- rd_strobe  out  1  1-cycle pulse when rd_data is latched for transmit.
- wr_en  out  1  1-cycle write strobe.
- wr_data  out  8  write data, valid while wr_en is high.
- busy  out  1  high while addressed (address match through STOP or NACK).
- stop_det  out  1  1-cycle pulse on any STOP condition.
- nack_rx  out  1  1-cycle pulse when the master NACKs a read byte.

Behaviour:
- Reset (reset=0, asynchronous):
  - outputs: sda_oe=0, wr_en=0, rd_strobe=0, stop_det=0, nack_rx=0, busy=0, wr_data=0, reg_addr=0;
  - internal: state=IDLE, bit counter=0, synchronizers preset to 1.
  - Applies immediately mid-transfer; SDA is released in the same cycle.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-FF synchronizer plus 1 history register.
  - Edge detects are 1-cycle pulses: scl_rise, scl_fall, sda_fall, sda_rise.
- Bus conditions:
  - START = sda_fall while synced SCL=1. STOP = sda_rise while synced SCL=1.
  - Both are detected in every state and take priority over bit events in the same cycle.
  - START: go to ADDR, bit count 0, sda_oe=0, pointer kept (repeated START).
  - STOP: go to IDLE, sda_oe=0, busy=0, stop_det pulse.
- Data timing:
  - SDA is sampled on scl_rise, MSB first.
  - sda_oe changes only on scl_fall.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits.
    - After the 8th scl_rise, if byte[7:1]==DEV_ADDR: set busy=1, latch the R/W bit; on the next scl_fall set sda_oe=1 and go to ADDR_ACK.
    - On mismatch: go to IDLE without ACK.
  - ADDR_ACK: on scl_fall ending the ACK clock:
    - W: sda_oe=0, go to PTR.
    - R: latch rd_data, pulse rd_strobe, sda_oe = ~bit7, go to RDATA.
  - PTR:
    - shift 8 bits; after the 8th scl_rise, reg_addr = byte;
    - ACK on the next scl_fall, go to PTR_ACK.
  - PTR_ACK: on scl_fall, release SDA and go to WDATA.
  - WDATA:
    - shift 8 bits; on the 8th scl_rise pulse wr_en with wr_data=byte and reg_addr unchanged;
    - ACK on the next scl_fall, go to WDATA_ACK.
  - WDATA_ACK: on scl_fall, release SDA, reg_addr += 1, go back to WDATA.
  - RDATA:
    - on each scl_fall, present the next bit (sda_oe = ~bit) for bits 6..0;
    - on the 8th scl_fall, sda_oe=0 and go to RDATA_ACK.
  - RDATA_ACK: on scl_rise, sample the master response and set reg_addr += 1 in both cases.
    - SDA=0 (ACK): on the next scl_fall latch rd_data, pulse rd_strobe, drive bit7, go to RDATA.
    - SDA=1 (NACK): pulse nack_rx, busy=0, go to IDLE (wait for STOP/START).
- Arithmetic: reg_addr increments modulo 256 (8'hFF wraps to 8'h00).
- Bus errors:
  - A STOP or START in the middle of a byte aborts it with no wr_en.
  - A partially shifted pointer byte leaves reg_addr unchanged.
- Read latency: rd_data is sampled in the single clk cycle of the scl_fall that begins each read byte.

Test Plan:
- Write: START, 0x90, 0x10, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; wr_en at addr 0x10 data 0xA5, then addr 0x11 data 0x5A; stop_det=1; reg_addr=0x12.
- Read: bank returns addr^0xFF; START, 0x90, 0x20, Sr, 0x91; master ACK, then NACK -> bytes 0xDF, 0xDE on SDA; 2 rd_strobe; nack_rx once; reg_addr=0x22.
- Address mismatch: START, 0x92, 0x10, 0x11, STOP -> sda_oe never 1; no wr_en; busy stays 0; stop_det=1.
- Wrap: write with pointer 0xFF and 2 data bytes -> wr_en at 0xFF, then at 0x00.
- Abort: STOP after 4 bits of a data byte -> no wr_en, state IDLE; next START, 0x90 is ACKed.
- Reset mid-read: reset=0 while sda_oe=1 -> sda_oe=0 in the same cycle; reg_addr=0; busy=0.

Source files
------------

// File: rtl/i2c_slave_regif.sv
// rtl/i2c_slave_regif.sv - I2C target bridging register-pointer transactions to a register bank
`timescale 1ns/1ps
module i2c_slave_regif #(
  parameter logic [6:0] DEV_ADDR = 7'h48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  input  logic [7:0] rd_data,
  output logic       rd_strobe,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       stop_det,
  output logic       nack_rx
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_hist_q, sda_hist_q;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, sda_rise, sda_fall;
  logic       start_cond, stop_cond;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [6:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_en_q, wr_en_d;
  logic       rd_strobe_q, rd_strobe_d;
  logic       busy_q, busy_d;
  logic       stop_det_q, stop_det_d;
  logic       nack_rx_q, nack_rx_d;
  logic [7:0] rx_byte;

  // Synchronizers idle high so reset never fabricates a bus edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  assign scl_s      = scl_sync_q[1];
  assign sda_s      = sda_sync_q[1];
  assign scl_rise   = scl_s & ~scl_hist_q;
  assign scl_fall   = ~scl_s & scl_hist_q;
  assign sda_rise   = sda_s & ~sda_hist_q;
  assign sda_fall   = ~sda_s & sda_hist_q;
  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;
  assign rx_byte    = {rx_q, sda_s};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rx_q        <= 7'd0;
      tx_q        <= 7'd0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= 8'd0;
      wr_data_q   <= 8'd0;
      wr_en_q     <= 1'b0;
      rd_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
      stop_det_q  <= 1'b0;
      nack_rx_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_strobe_q <= rd_strobe_d;
      busy_q      <= busy_d;
      stop_det_q  <= stop_det_d;
      nack_rx_q   <= nack_rx_d;
    end
  end

  // cnt_q == 8 marks "byte received, ACK pending on next scl_fall".
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    rd_strobe_d = 1'b0;
    busy_d      = busy_q;
    stop_det_d  = 1'b0;
    nack_rx_d   = 1'b0;

    if (stop_cond) begin
      state_d    = IDLE;
      cnt_d      = 4'd0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else if (start_cond) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR, PTR, WDATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            rx_d  = rx_byte[6:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (state_q == ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  busy_d = 1'b1;
                  rw_d   = rx_byte[0];
                end else begin
                  state_d = IDLE;
                  cnt_d   = 4'd0;
                end
              end else if (state_q == PTR) begin
                reg_addr_d = rx_byte;
              end else begin
                wr_en_d   = 1'b1;
                wr_data_d = rx_byte;
              end
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            cnt_d    = 4'd0;
            state_d  = (state_q == ADDR) ? ADDR_ACK :
                       (state_q == PTR)  ? PTR_ACK  : WDATA_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (rw_q) begin
              tx_d        = rd_data[6:0];
              rd_strobe_d = 1'b1;
              sda_oe_d    = ~rd_data[7];
              state_d     = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = PTR;
            end
          end
        end
        PTR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = WDATA;
          end
        end
        WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d   = 1'b0;
            cnt_d      = 4'd0;
            reg_addr_d = reg_addr_q + 8'd1;
            state_d    = WDATA;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = RDATA_ACK;
            end else begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise && cnt_q == 4'd0) begin
            reg_addr_d = reg_addr_q + 8'd1;
            if (!sda_s) begin
              cnt_d = 4'd8;
            end else begin
              nack_rx_d = 1'b1;
              busy_d    = 1'b0;
              state_d   = IDLE;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            tx_d        = rd_data[6:0];
            rd_strobe_d = 1'b1;
            sda_oe_d    = ~rd_data[7];
            cnt_d       = 4'd0;
            state_d     = RDATA;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign rd_strobe = rd_strobe_q;
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign stop_det  = stop_det_q;
  assign nack_rx   = nack_rx_q;

endmodule
